// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: PRGA state encoding, printable-range defaults and
// the printable-byte test that the key cracker also uses.
package arc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_LEN,
    ST_CAP_LEN,
    ST_WR_LEN,
    ST_RD_SI,
    ST_CAP_SI,
    ST_RD_SJ,
    ST_CAP_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_PAD,
    ST_CAP_PAD,
    ST_WR_PT,
    ST_DONE
  } prga_state_t;

  localparam logic [7:0] PRINT_LO_DEF = 8'h20;
  localparam logic [7:0] PRINT_HI_DEF = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation stage: decrypts length-prefixed CT into PT.
// Optional ARC4_PRGA_EARLY_ABORT_EN stops a run at the first non-printable byte.
module arc4_prga
  import arc4_pkg::*;
#(
  parameter logic [7:0] PRINT_LO = PRINT_LO_DEF,
  parameter logic [7:0] PRINT_HI = PRINT_HI_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       abort,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

`ifdef ARC4_PRGA_EARLY_ABORT_EN
  localparam logic EARLY_ABORT = 1'b1;
`else
  localparam logic EARLY_ABORT = 1'b0;
`endif

  prga_state_t r_state;
  logic        r_rdy;
  logic        r_abort;
  logic        r_stop;
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [7:0]  r_k;
  logic [7:0]  r_len;
  logic [7:0]  r_si;
  logic [7:0]  r_sj;
  logic [7:0]  r_pt_byte;
  logic [7:0]  r_s_addr;
  logic [7:0]  r_s_wrdata;
  logic        r_s_wren;
  logic [7:0]  r_ct_addr;
  logic [7:0]  r_pt_addr;
  logic        r_pt_wren;

  logic [7:0]  w_pad_byte;
  logic [7:0]  w_i_inc;
  logic [7:0]  w_j_new;

  assign w_pad_byte = s_rddata ^ ct_rddata;
  assign w_i_inc    = r_i + 8'd1;
  assign w_j_new    = r_j + s_rddata;

  // Outputs are registered: each state's memory address/strobe is loaded on
  // the edge that enters that state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rdy      <= 1'b1;
      r_abort    <= 1'b0;
      r_stop     <= 1'b0;
      r_i        <= 8'd0;
      r_j        <= 8'd0;
      r_k        <= 8'd0;
      r_len      <= 8'd0;
      r_si       <= 8'd0;
      r_sj       <= 8'd0;
      r_pt_byte  <= 8'd0;
      r_s_addr   <= 8'd0;
      r_s_wrdata <= 8'd0;
      r_s_wren   <= 1'b0;
      r_ct_addr  <= 8'd0;
      r_pt_addr  <= 8'd0;
      r_pt_wren  <= 1'b0;
    end else begin
      r_s_wren  <= 1'b0;
      r_pt_wren <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (en) begin
            r_state   <= ST_RD_LEN;
            r_rdy     <= 1'b0;
            r_abort   <= 1'b0;
            r_stop    <= 1'b0;
            r_i       <= 8'd0;
            r_j       <= 8'd0;
            r_k       <= 8'd0;
            r_ct_addr <= 8'd0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_LEN: r_state <= ST_CAP_LEN;
        ST_CAP_LEN: begin
          r_len     <= ct_rddata;
          r_pt_byte <= ct_rddata;
          r_pt_addr <= 8'd0;
          r_pt_wren <= 1'b1;
          r_state   <= ST_WR_LEN;
        end
        ST_WR_LEN: begin
          if (r_len == 8'd0) begin
            r_rdy   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_k      <= 8'd1;
            r_i      <= w_i_inc;
            r_s_addr <= w_i_inc;
            r_state  <= ST_RD_SI;
          end
        end
        ST_RD_SI: r_state <= ST_CAP_SI;
        ST_CAP_SI: begin
          r_si     <= s_rddata;
          r_j      <= w_j_new;
          r_s_addr <= w_j_new;
          r_state  <= ST_RD_SJ;
        end
        ST_RD_SJ: r_state <= ST_CAP_SJ;
        ST_CAP_SJ: begin
          r_sj       <= s_rddata;
          r_s_addr   <= r_i;
          r_s_wrdata <= s_rddata;
          r_s_wren   <= 1'b1;
          r_state    <= ST_WR_SI;
        end
        // When i==j both swap writes hit one address with the same value.
        ST_WR_SI: begin
          r_s_addr   <= r_j;
          r_s_wrdata <= r_si;
          r_s_wren   <= 1'b1;
          r_state    <= ST_WR_SJ;
        end
        ST_WR_SJ: begin
          r_s_addr  <= r_si + r_sj;
          r_ct_addr <= r_k;
          r_state   <= ST_RD_PAD;
        end
        ST_RD_PAD: r_state <= ST_CAP_PAD;
        ST_CAP_PAD: begin
          r_pt_byte <= w_pad_byte;
          r_pt_addr <= r_k;
          r_pt_wren <= 1'b1;
          r_stop    <= EARLY_ABORT && !is_printable(w_pad_byte, PRINT_LO, PRINT_HI);
          r_state   <= ST_WR_PT;
        end
        ST_WR_PT: begin
          if ((r_k == r_len) || r_stop) begin
            r_rdy   <= 1'b1;
            r_abort <= r_stop;
            r_state <= ST_DONE;
          end else begin
            r_k      <= r_k + 8'd1;
            r_i      <= w_i_inc;
            r_s_addr <= w_i_inc;
            r_state  <= ST_RD_SI;
          end
        end
        default: begin
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdy       = r_rdy;
  assign abort     = r_abort;
  assign s_addr    = r_s_addr;
  assign s_wrdata  = r_s_wrdata;
  assign s_wren    = r_s_wren;
  assign ct_addr   = r_ct_addr;
  assign pt_addr   = r_pt_addr;
  assign pt_wrdata = r_pt_byte;
  assign pt_wren   = r_pt_wren;

endmodule

// File: tb/tb_arc4_prga.sv
// Scoreboard bench for arc4_prga: expected PT writes are queued by the
// stimulus and checked by a monitor; run latency and S contents checked inline.
module tb_arc4_prga;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy, abort;
  logic [7:0] s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
  logic [7:0] s_rddata, ct_rddata;
  logic       s_wren, pt_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_img [256];
  logic       do_init = 1'b0;

  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int s_wr_cnt = 0;

  arc4_prga dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .abort(abort),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always #5 clk = ~clk;

  // Memory models with one-cycle read latency.
  always @(posedge clk) begin
    if (do_init) begin
      for (int x = 0; x < 256; x++) begin
        s_mem[x]  <= 8'(x);
        pt_mem[x] <= 8'hAA;
      end
    end else begin
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_img[ct_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every PT write is popped against the scoreboard queue.
  always @(negedge clk) begin
    if (s_wren) s_wr_cnt++;
    if (rst_n && pt_wren) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pt_write_unexpected got=%02h:%02h exp=none", pt_addr, pt_wrdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("pt_write", {pt_addr, pt_wrdata}, e);
        $display("pt write addr=%0d data=%02h", pt_addr, pt_wrdata);
      end
    end
  end

  task automatic load(input logic [7:0] b0, b1, b2, b3);
    ct_img[0] = b0; ct_img[1] = b1; ct_img[2] = b2; ct_img[3] = b3;
    @(negedge clk); do_init = 1'b1;
    @(negedge clk); do_init = 1'b0;
  endtask

  task automatic expect_pt(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Called at a negedge; lat counts edges from accept through rdy rising.
  task automatic run_wait(output int lat);
    en = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    en = 1'b0;
    while (!rdy && lat < 3000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_swapped_s(input string tag);
    chk({tag, "_s2"}, s_mem[2], 8'h03);
    chk({tag, "_s3"}, s_mem[3], 8'h05);
    chk({tag, "_s5"}, s_mem[5], 8'h02);
  endtask

  task automatic run_printable(input string tag);
    int lat;
    load(8'd3, 8'h43, 8'h47, 8'h48);
    expect_pt(0, 8'h03); expect_pt(1, 8'h41); expect_pt(2, 8'h42); expect_pt(3, 8'h4F);
    run_wait(lat);
    chk({tag, "_latency"}, lat, 31);
    chk({tag, "_abort"}, abort, 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_pt3"}, pt_mem[3], 8'h4F);
    check_swapped_s(tag);
    $display("%s: latency=%0d abort=%0b", tag, lat, abort);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, miss, rdy_hi;
    for (int x = 0; x < 256; x++) ct_img[x] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rdy", rdy, 1);
    chk("rst_abort", abort, 0);
    chk("rst_s_wren", s_wren, 0);
    chk("rst_pt_wren", pt_wren, 0);
    chk("rst_addrs", {s_addr, ct_addr, pt_addr}, 0);
    chk("rst_data", {s_wrdata, pt_wrdata}, 0);
    $display("reset: rdy=%0b abort=%0b", rdy, abort);

    run_printable("t2");

`ifdef ARC4_PRGA_EARLY_ABORT_EN
    load(8'd3, 8'h00, 8'h00, 8'h00);
    expect_pt(0, 8'h03); expect_pt(1, 8'h02);
    run_wait(lat);
    chk("t3_latency", lat, 13);
    chk("t3_abort", abort, 1);
    chk("t3_pending", exp_q.size(), 0);
    chk("t3_pt1", pt_mem[1], 8'h02);
    chk("t3_pt2_untouched", pt_mem[2], 8'hAA);
    chk("t3_pt3_untouched", pt_mem[3], 8'hAA);
    $display("t3: latency=%0d abort=%0b", lat, abort);
`else
    load(8'd3, 8'h00, 8'h00, 8'h00);
    expect_pt(0, 8'h03); expect_pt(1, 8'h02); expect_pt(2, 8'h05); expect_pt(3, 8'h07);
    run_wait(lat);
    chk("t1_latency", lat, 31);
    chk("t1_abort", abort, 0);
    chk("t1_pending", exp_q.size(), 0);
    chk("t1_pt2", pt_mem[2], 8'h05);
    check_swapped_s("t1");
    $display("t1: latency=%0d abort=%0b", lat, abort);
`endif

    // Zero-length message.
    load(8'd0, 8'h11, 8'h22, 8'h33);
    expect_pt(0, 8'h00);
    s0 = s_wr_cnt;
    run_wait(lat);
    chk("t4_latency", lat, 4);
    chk("t4_s_writes", s_wr_cnt - s0, 0);
    chk("t4_pending", exp_q.size(), 0);
    chk("t4_pt1_untouched", pt_mem[1], 8'hAA);
    $display("t4: latency=%0d s_writes=%0d", lat, s_wr_cnt - s0);

    // Reset pulse in the middle of an S write.
    load(8'd3, 8'h43, 8'h47, 8'h48);
    expect_pt(0, 8'h03);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    miss = 1;
    for (int n = 0; n < 100; n++) begin
      if (s_wren) begin miss = 0; break; end
      @(negedge clk);
    end
    chk("t5_reached_write", miss, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rdy", rdy, 1);
    chk("t5_s_wren", s_wren, 0);
    chk("t5_pt_wren", pt_wren, 0);
    chk("t5_abort", abort, 0);
    chk("t5_pending", exp_q.size(), 0);
    exp_q.delete();
    $display("t5: after reset rdy=%0b s_wren=%0b", rdy, s_wren);
    run_printable("t5_rerun");

    // en held high: one run per rdy window, back-to-back 4-cycle runs.
    load(8'd0, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 10; n++) expect_pt(0, 8'h00);
    s0 = s_wr_cnt;
    miss = 0;
    rdy_hi = 0;
    en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy) rdy_hi++;
      if (rdy !== ((n % 4) == 3)) miss++;
    end
    en = 1'b0;
    chk("t6_rdy_pattern", miss, 0);
    chk("t6_rdy_windows", rdy_hi, 10);
    chk("t6_pending", exp_q.size(), 0);
    chk("t6_s_writes", s_wr_cnt - s0, 0);
    repeat (3) @(negedge clk);
    chk("t6_idle_rdy", rdy, 1);
    $display("t6: rdy_windows=%0d pattern_errors=%0d", rdy_hi, miss);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arc4_prga.md
Name: arc4_prga

Overview:
- Pseudo-random generation stage of the ARC4 decrypt datapath. Runs after the KSA has left a permuted S array in S memory.
- Reads the length-prefixed ciphertext, generates one keystream byte per message byte, and writes the length-prefixed plaintext into PT memory.
- The brute-force cracker reads that PT memory to judge each candidate key.
- With the optional feature, the block aborts on the first non-printable byte to shorten each key trial.

Parameters:
- PRINT_LO, 8'h20: lowest printable byte value.
- PRINT_HI, 8'h7E: highest printable byte value.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  idle/ready for a new run
- abort  out  1  last run stopped on a non-printable byte
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data, valid 1 cycle after address
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- ct_addr  out  8  CT memory address
- ct_rddata  in  8  CT read data, 1-cycle latency
- pt_addr  out  8  PT memory address
- pt_wrdata  out  8  PT write data
- pt_wren  out  1  PT write enable

Behaviour:
- Reset (clk edge with rst_n=0), from any state including mid-run:
  - state=IDLE, rdy=1, abort=0.
  - i=j=k=0, len=0.
  - All wren=0, all addresses and data=0.
- Handshake:
  - en=1 while rdy=1 starts a run; rdy=0 from the next cycle.
  - en is ignored while busy.
  - abort clears at start.
  - rdy returns to 1 in DONE and stays 1 until the next start.
- Memories: read data is valid in the cycle after the address is presented. Write enables are asserted for exactly one cycle per write.
- States:
  - IDLE: wait for en.
  - RD_LEN: ct_addr=0.
  - CAP_LEN: len<=ct_rddata.
  - WR_LEN: pt[0]=len. If len==0 go to DONE, else k=1 and go to RD_SI.
  - RD_SI: i<=i+1; s_addr=i+1.
  - CAP_SI: si<=s_rddata; j<=j+s_rddata.
  - RD_SJ: s_addr=j.
  - CAP_SJ: sj<=s_rddata.
  - WR_SI: s[i]=sj.
  - WR_SJ: s[j]=si.
  - RD_PAD: s_addr=si+sj; ct_addr=k.
  - CAP_PAD: pt_byte<=s_rddata^ct_rddata.
  - WR_PT: pt[k]=pt_byte. If k==len go to DONE, else k<=k+1 and go to RD_SI.
  - DONE: rdy=1, then IDLE.
- Timing:
  - Exactly 9 cycles per message byte.
  - Run latency from en accepted to rdy=1 is 4+9*len cycles.
- Arithmetic: i, j and si+sj are 8-bit, wrapping mod 256. k counts 1..len, and len=255 is legal.
- Aliasing: when i==j, both writes target the same address with the same value. This is legal and needs no special case.

Optional Feature:
- ARC4_PRGA_EARLY_ABORT_EN defined:
  - In CAP_PAD, a pt_byte outside [PRINT_LO, PRINT_HI] still gets written in WR_PT.
  - Next state is then DONE with abort=1.
  - Remaining bytes are not processed; latency becomes 4+9*n for n bytes processed.
- Macro undefined:
  - abort is tied to 0.
  - All len bytes are always processed.

Decomposition:
- Shared package arc4_pkg holds:
  - prga_state_t enum.
  - PRINT_LO and PRINT_HI defaults.
  - is_printable(byte) function, reused by the cracker.
- No sub-module; the block is a single FSM with datapath registers i, j, k, len, si, sj, pt_byte.

Test Plan:
1. S identity (s[x]=x), ct={3,00,00,00}, macro undefined:
   - pt={03,02,05,07}.
   - S afterwards: s[2]=3, s[3]=5, s[5]=2.
   - rdy rises 31 cycles after en accepted.
2. S identity, ct={3,43,47,48}:
   - pt={03,41,42,4F}.
   - abort=0 with the macro defined.
3. With ARC4_PRGA_EARLY_ABORT_EN, S identity, ct={3,00,00,00}:
   - pt[1]=02 is written.
   - abort=1; rdy rises 13 cycles after en accepted.
   - pt[2] and pt[3] are untouched.
4. ct[0]=0:
   - pt[0]=00 is the only write; no S writes occur.
   - rdy returns 4 cycles after en accepted.
5. rst_n=0 for one cycle during a write state:
   - Next cycle rdy=1, all wren=0, abort=0.
   - A fresh run of test 1 then reproduces test 1 results, given S memory is reloaded to identity first.
6. en held high throughout a run:
   - Exactly one run per rdy=1 window.
   - en during busy has no effect; a new run starts on the cycle after DONE.
